kitchen_timer_ctrl: RTL and testbench
=====================================

KITCHEN_TIMER_CTRL -- requirements
Module: kitchen_timer_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low (rst_n); all other logic is synchronous to clk.
REQ-002 Parameter TICKS_PER_SEC, default 100_000_000: clk cycles per counted second.
REQ-003 Parameter ALARM_SECS, default 10: seconds DONE is held before auto-return to IDLE.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 btn_start  in  1  debounced one-cycle pulse: start/pause toggle.
REQ-007 btn_clear  in  1  debounced one-cycle pulse: clear time, abort.
REQ-008 btn_min_inc  in  1  debounced one-cycle pulse: +1 minute (IDLE only).
REQ-009 btn_sec_inc  in  1  debounced one-cycle pulse: +1 second (IDLE only).
REQ-010 min1, min0, sec1, sec0  out  4 each  BCD digits to the segment encoder: minutes tens, minutes ones, seconds tens, seconds ones.
REQ-011 running  out  1  high in RUN.
REQ-012 alarm  out  1  high in DONE.
REQ-013 blank  out  1  display blank request; toggles every half second in DONE, else 0.

Function
REQ-014 States SHALL be IDLE, RUN, PAUSE, DONE; all outputs registered, updating the cycle after the causing input.
REQ-015 Digits SHALL always be valid BCD: minutes 00..99, seconds 00..59.
REQ-016 IDLE: btn_min_inc adds 1 minute, 99 wraps to 00; btn_sec_inc adds 1 second, 59 wraps to 00 with no carry into minutes; both same cycle both apply.
REQ-017 IDLE: btn_start with time 00:00 ignored; nonzero -> RUN with prescaler cleared to 0.
REQ-018 RUN: prescaler counts 0..TICKS_PER_SEC-1; on terminal count time decrements 1 s with BCD borrow (sec0 0->9 borrows sec1; sec1 0->5 borrows min0; min0 0->9 borrows min1).
REQ-019 RUN: the decrement reaching 00:00 SHALL enter DONE on that same edge.
REQ-020 RUN: btn_start -> PAUSE, prescaler value held; a coincident tick is applied first.
REQ-021 PAUSE: btn_start -> RUN, prescaler resumes from held value; inc buttons ignored.
REQ-022 In RUN, PAUSE, DONE the inc buttons SHALL be ignored.
REQ-023 btn_clear in any state -> IDLE, digits 00:00, prescaler 0; clear has priority over start and inc in the same cycle.
REQ-024 DONE: digits 00:00, alarm=1, blank starts 0 and toggles every TICKS_PER_SEC/2 cycles; btn_start or btn_clear -> IDLE; after ALARM_SECS seconds -> IDLE automatically.
REQ-025 On leaving DONE alarm and blank SHALL be 0 in the following cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, all digits 0, running=0, alarm=0, blank=0, prescaler and alarm counters 0, including mid-countdown.
REQ-027 After rst_n deasserts, the first button pulse SHALL be honoured on the next clk edge.

Structure
REQ-028 Shared package kitchen_timer_pkg SHALL hold the state encoding, BCD max-digit constants (9, 5) and the default TICKS_PER_SEC.
REQ-029 One sub-module, tick_gen (prescaler with enable, clear, second-tick and half-second-tick outputs), SHALL be instantiated; the BCD counter and FSM stay in kitchen_timer_ctrl.

Verification (TICKS_PER_SEC=4, ALARM_SECS=2)
REQ-030 Reset then 3 btn_sec_inc, 1 btn_min_inc, btn_start -> 01:03, running=1; after 4 clks 01:02; after 63 s total DONE, alarm=1, 00:00.
REQ-031 Set 10:00, start, one tick -> 09:59 (double borrow); set 00:59 via 59 sec_inc then one more -> 00:00, minutes unchanged.
REQ-032 RUN at 00:05, btn_start at prescaler=2 -> PAUSE, digits frozen 8 clks; btn_start -> decrement exactly 2 clks later.
REQ-033 btn_start and btn_clear in the same RUN cycle -> IDLE, 00:00, running=0.
REQ-034 DONE with no input -> blank toggles every 2 clks, IDLE after 8 clks, alarm=0; btn_start at 00:00 in IDLE -> stays IDLE.
REQ-035 rst_n pulsed low mid-RUN at 05:30 -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/kitchen_timer_pkg.sv
// Kitchen timer shared types and constants.
// BCD helpers return {carry_or_borrow, digit}.
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  localparam int DEF_TICKS_PER_SEC = 100_000_000;
  localparam int DEF_ALARM_SECS    = 10;

  function automatic logic [4:0] bcd_inc(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return (d == max) ? 5'b10000 : {1'b0, d + 4'd1};
  endfunction

  function automatic logic [4:0] bcd_dec(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return (d == 4'd0) ? {1'b1, max} : {1'b0, d - 4'd1};
  endfunction

endpackage

// File: rtl/kitchen_timer_if.sv
// Button inputs and display/status outputs of the timer.
// master = front panel, slave = controller.
interface kitchen_timer_if;

  logic       btn_start;
  logic       btn_clear;
  logic       btn_min_inc;
  logic       btn_sec_inc;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic       running;
  logic       alarm;
  logic       blank;

  modport master (
    output btn_start, btn_clear,
    output btn_min_inc, btn_sec_inc,
    input  min1, min0, sec1, sec0,
    input  running, alarm, blank
  );

  modport slave (
    input  btn_start, btn_clear,
    input  btn_min_inc, btn_sec_inc,
    output min1, min0, sec1, sec0,
    output running, alarm, blank
  );

endinterface

// File: rtl/tick_gen.sv
// Seconds prescaler with second and half-second ticks.
// hold freezes the count unless a tick is due this cycle.
module tick_gen #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  input  logic clr,
  output logic sec_tick,
  output logic half_tick
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int H = (TICKS / 2 > 0) ? TICKS / 2 - 1 : 0;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);
  localparam logic [W-1:0] HALF = W'(H);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last, at_half;

  assign at_last   = (cnt_q == LAST);
  assign at_half   = (cnt_q == HALF);
  assign sec_tick  = en & at_last;
  assign half_tick = en & (at_half | at_last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (!hold || at_last)) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen countdown timer: BCD MM:SS counter plus run/pause/alarm FSM.
// All outputs are registered from next-state values.
module kitchen_timer_ctrl
  import kitchen_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int ALARM_SECS    = DEF_ALARM_SECS
) (
  input  logic           clk,
  input  logic           rst_n,
  kitchen_timer_if.slave bus
);

  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(ALARM_SECS - 1);

  state_e        st_q, st_d;
  logic [3:0]    m1_q, m1_d, m0_q, m0_d;
  logic [3:0]    s1_q, s1_d, s0_q, s0_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          running_q, alarm_q;
  logic          blank_q, blank_d;
  logic          sec_tick, half_tick;
  logic          pre_en, pre_hold, pre_clr;
  logic [4:0]    is0, is1, im0, im1;
  logic [4:0]    ds0, ds1, dm0, dm1;
  logic          nonzero, is_one;

  assign pre_en   = !bus.btn_clear &&
                    (st_q == ST_RUN || st_q == ST_DONE);
  assign pre_hold = (st_q == ST_RUN) && bus.btn_start;
  assign pre_clr  = bus.btn_clear || (st_q == ST_IDLE);

  tick_gen #(
    .TICKS (TICKS_PER_SEC)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pre_en),
    .hold      (pre_hold),
    .clr       (pre_clr),
    .sec_tick  (sec_tick),
    .half_tick (half_tick)
  );

  assign is0 = bcd_inc(s0_q, BCD_MAX9);
  assign is1 = bcd_inc(s1_q, BCD_MAX5);
  assign im0 = bcd_inc(m0_q, BCD_MAX9);
  assign im1 = bcd_inc(m1_q, BCD_MAX9);
  assign ds0 = bcd_dec(s0_q, BCD_MAX9);
  assign ds1 = bcd_dec(s1_q, BCD_MAX5);
  assign dm0 = bcd_dec(m0_q, BCD_MAX9);
  assign dm1 = bcd_dec(m1_q, BCD_MAX9);

  assign nonzero = |{m1_q, m0_q, s1_q, s0_q};
  assign is_one  = ({m1_q, m0_q, s1_q, s0_q} == 16'h0001);

  always_comb begin
    st_d   = st_q;
    m1_d   = m1_q;
    m0_d   = m0_q;
    s1_d   = s1_q;
    s0_d   = s0_q;
    acnt_d = acnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (bus.btn_sec_inc) begin
          s0_d = is0[3:0];
          if (is0[4]) s1_d = is1[3:0];
        end
        if (bus.btn_min_inc) begin
          m0_d = im0[3:0];
          if (im0[4]) m1_d = im1[3:0];
        end
        if (bus.btn_start && nonzero) st_d = ST_RUN;
      end
      ST_RUN: begin
        if (sec_tick) begin
          s0_d = ds0[3:0];
          if (ds0[4]) s1_d = ds1[3:0];
          if (ds0[4] && ds1[4]) m0_d = dm0[3:0];
          if (ds0[4] && ds1[4] && dm0[4]) m1_d = dm1[3:0];
        end
        // an expiring tick wins over a pause request
        if (sec_tick && is_one) st_d = ST_DONE;
        else if (bus.btn_start) st_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus.btn_start) st_d = ST_RUN;
      end
      ST_DONE: begin
        if (bus.btn_start) begin
          st_d = ST_IDLE;
        end else if (sec_tick) begin
          if (acnt_q == A_LAST) st_d = ST_IDLE;
          else acnt_d = acnt_q + AW'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (bus.btn_clear) begin
      st_d = ST_IDLE;
      m1_d = '0;
      m0_d = '0;
      s1_d = '0;
      s0_d = '0;
    end
    if (st_d != ST_DONE) acnt_d = '0;
    blank_d = (st_q == ST_DONE && st_d == ST_DONE) ?
              (blank_q ^ half_tick) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      m1_q      <= '0;
      m0_q      <= '0;
      s1_q      <= '0;
      s0_q      <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      m1_q      <= m1_d;
      m0_q      <= m0_d;
      s1_q      <= s1_d;
      s0_q      <= s0_d;
      acnt_q    <= acnt_d;
      running_q <= (st_d == ST_RUN);
      alarm_q   <= (st_d == ST_DONE);
      blank_q   <= blank_d;
    end
  end

  assign bus.min1    = m1_q;
  assign bus.min0    = m0_q;
  assign bus.sec1    = s1_q;
  assign bus.sec0    = s0_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
  assign bus.blank   = blank_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Directed bench for kitchen_timer_ctrl, TICKS_PER_SEC=4, ALARM_SECS=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_kitchen_timer_ctrl;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_CLEAR = 4'b0010;
  localparam logic [3:0] B_MIN   = 4'b0100;
  localparam logic [3:0] B_SEC   = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  int         checks = 0;
  int         fails = 0;

  kitchen_timer_if ifc ();

  assign ifc.btn_start   = btn[0];
  assign ifc.btn_clear   = btn[1];
  assign ifc.btn_min_inc = btn[2];
  assign ifc.btn_sec_inc = btn[3];

  kitchen_timer_ctrl #(
    .TICKS_PER_SEC (4),
    .ALARM_SECS    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] tm;
  assign tm = {ifc.min1, ifc.min0, ifc.sec1, ifc.sec0};

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a falling edge; the pulse spans exactly one rising edge
  task automatic press(input logic [3:0] b);
    btn = b;
    @(negedge clk);
    btn = '0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_n(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    #12;
    chk("rst_time", tm, 16'h0000);
    chk("rst_running", {15'd0, ifc.running}, 16'd0);
    chk("rst_alarm", {15'd0, ifc.alarm}, 16'd0);
    chk("rst_blank", {15'd0, ifc.blank}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first press right after reset release
    press(B_SEC);
    chk("first_press", tm, 16'h0001);
    press_n(B_SEC, 2);
    press(B_MIN);
    chk("set_0103", tm, 16'h0103);
    press(B_START);
    chk("start_time", tm, 16'h0103);
    chk("start_running", {15'd0, ifc.running}, 16'd1);
    wait_clks(3);
    chk("pre_tick", tm, 16'h0103);
    wait_clks(1);
    chk("tick1", tm, 16'h0102);
    wait_clks(247);
    chk("last_sec", tm, 16'h0001);
    chk("last_alarm", {15'd0, ifc.alarm}, 16'd0);
    wait_clks(1);
    chk("done_time", tm, 16'h0000);
    chk("done_alarm", {15'd0, ifc.alarm}, 16'd1);
    chk("done_running", {15'd0, ifc.running}, 16'd0);
    chk("done_blank0", {15'd0, ifc.blank}, 16'd0);

    // DONE blink and auto-return
    wait_clks(1);
    chk("blank_d1", {15'd0, ifc.blank}, 16'd0);
    wait_clks(1);
    chk("blank_d2", {15'd0, ifc.blank}, 16'd1);
    wait_clks(2);
    chk("blank_d4", {15'd0, ifc.blank}, 16'd0);
    chk("alarm_d4", {15'd0, ifc.alarm}, 16'd1);
    wait_clks(3);
    chk("blank_d7", {15'd0, ifc.blank}, 16'd1);
    chk("alarm_d7", {15'd0, ifc.alarm}, 16'd1);
    wait_clks(1);
    chk("auto_idle_alarm", {15'd0, ifc.alarm}, 16'd0);
    chk("auto_idle_blank", {15'd0, ifc.blank}, 16'd0);
    press(B_START);
    chk("start_zero_run", {15'd0, ifc.running}, 16'd0);
    chk("start_zero_time", tm, 16'h0000);

    // double borrow 10:00 -> 09:59
    press_n(B_MIN, 10);
    chk("set_1000", tm, 16'h1000);
    press(B_START);
    wait_clks(4);
    chk("borrow", tm, 16'h0959);
    press(B_CLEAR);
    chk("clr_time", tm, 16'h0000);
    chk("clr_running", {15'd0, ifc.running}, 16'd0);

    // seconds and minutes wrap
    press_n(B_SEC, 59);
    chk("set_0059", tm, 16'h0059);
    press(B_SEC);
    chk("sec_wrap", tm, 16'h0000);
    press_n(B_MIN, 99);
    chk("set_9900", tm, 16'h9900);
    press(B_MIN);
    chk("min_wrap", tm, 16'h0000);
    press(B_MIN | B_SEC);
    chk("both_inc", tm, 16'h0101);
    press(B_CLEAR);

    // pause at prescaler 2, resume
    press_n(B_SEC, 5);
    press(B_START);
    wait_clks(2);
    press(B_START);
    chk("pause_running", {15'd0, ifc.running}, 16'd0);
    chk("pause_time", tm, 16'h0005);
    press(B_MIN);
    wait_clks(7);
    chk("pause_frozen", tm, 16'h0005);
    press(B_START);
    chk("resume_running", {15'd0, ifc.running}, 16'd1);
    wait_clks(1);
    chk("resume_r1", tm, 16'h0005);
    wait_clks(1);
    chk("resume_r2", tm, 16'h0004);

    // clear beats start in RUN
    press(B_START | B_CLEAR);
    chk("clr_start_time", tm, 16'h0000);
    chk("clr_start_run", {15'd0, ifc.running}, 16'd0);

    // async reset mid-run at 05:30
    press_n(B_MIN, 5);
    press_n(B_SEC, 30);
    press(B_START);
    wait_clks(2);
    chk("pre_rst_run", {15'd0, ifc.running}, 16'd1);
    chk("pre_rst_time", tm, 16'h0530);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_time", tm, 16'h0000);
    chk("async_run", {15'd0, ifc.running}, 16'd0);
    chk("async_alarm", {15'd0, ifc.alarm}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(4);
    chk("post_rst_run", {15'd0, ifc.running}, 16'd0);
    chk("post_rst_time", tm, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
